// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative RV32M multiply/divide sequencer beside the EX-stage ALU
//   clk, rst_n (async, active-low)
//   i_start/i_func3/i_op1/i_op2/i_rd : M-extension op from the EX operand muxes
//   i_flush  : kill in-flight op
//   o_stall  : combinational pipeline hold
//   o_valid/o_result/o_rd : registered one-cycle result
module ex_muldiv_ctrl #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_func3,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   input  logic [4:0]      i_rd,
   input  logic            i_flush,
   output logic            o_stall,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]        r_state;
   logic [4:0]        r_cnt;
   logic [2:0]        r_func3;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_m;
   logic [2*XLEN-1:0] r_acc;
   logic              r_neg;
   logic              r_spec;
   logic [XLEN-1:0]   r_spec_val;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;
   logic              w_div, w_s1, w_s2, w_n1, w_n2, w_neg;
   logic [XLEN-1:0]   w_a1, w_a2;
   logic              w_div0, w_ovf, w_mulz, w_spec;
   logic [XLEN-1:0]   w_spec_val;
   logic [XLEN:0]     w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0] w_acc_nx, w_prod;
   logic [XLEN-1:0]   w_div_sel, w_div_res, w_calc_res;
   // Operand signedness: DIV/REM signed, DIVU/REMU not; MULHSU signs op1 only, MULHU neither.
   assign w_div  = i_func3[2];
   assign w_s1   = w_div ? ~i_func3[0] : (i_func3[1:0] != 2'b11);
   assign w_s2   = w_div ? ~i_func3[0] : ~i_func3[1];
   assign w_n1   = w_s1 & i_op1[XLEN-1];
   assign w_n2   = w_s2 & i_op2[XLEN-1];
   assign w_a1   = w_n1 ? -i_op1 : i_op1;
   assign w_a2   = w_n2 ? -i_op2 : i_op2;
   // Remainders follow the dividend sign; everything else is the sign product.
   assign w_neg  = (w_div & i_func3[1]) ? w_n1 : (w_n1 ^ w_n2);
   assign w_div0 = w_div & (i_op2 == '0);
   assign w_ovf  = w_div & ~i_func3[0] & (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_op2 == '1);
   assign w_mulz = ~w_div & ((i_op1 == '0) | (i_op2 == '0));
   assign w_spec = w_div0 | w_ovf | w_mulz;
   assign w_spec_val = w_div0 ? (i_func3[1] ? i_op1 : '1) :
                       w_ovf  ? (i_func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}}) : '0;
   // r_acc: multiply = {partial sum, multiplier shifting out}; divide = {remainder, quotient/dividend}.
   assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
   assign w_shift  = r_acc[2*XLEN-1:XLEN-1];
   assign w_diff   = w_shift - {1'b0, r_m};
   assign w_acc_nx = ~r_func3[2] ? {w_sum, r_acc[XLEN-1:1]} :
                     w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                                    {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
   assign w_prod     = r_neg ? -w_acc_nx : w_acc_nx;
   assign w_div_sel  = r_func3[1] ? w_acc_nx[2*XLEN-1:XLEN] : w_acc_nx[XLEN-1:0];
   assign w_div_res  = r_neg ? -w_div_sel : w_div_sel;
   assign w_calc_res = r_spec ? r_spec_val :
                       r_func3[2] ? w_div_res :
                       (r_func3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   assign o_stall  = ((r_state == IDLE) & i_start & ~i_flush) | (r_state == CALC);
   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_rd     = r_rd;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_func3    <= '0;
         r_rd       <= '0;
         r_m        <= '0;
         r_acc      <= '0;
         r_neg      <= 1'b0;
         r_spec     <= 1'b0;
         r_spec_val <= '0;
         r_valid    <= 1'b0;
         r_result   <= '0;
      end else begin
         r_valid <= 1'b0;
         if (i_flush) r_state <= IDLE;
         else case (r_state)
            IDLE: if (i_start) begin
               r_func3    <= i_func3;
               r_rd       <= i_rd;
               r_neg      <= w_neg;
               r_spec     <= w_spec;
               r_spec_val <= w_spec_val;
               r_cnt      <= '0;
               r_m        <= w_div ? w_a2 : w_a1;
               r_acc      <= {{XLEN{1'b0}}, w_div ? w_a1 : w_a2};
               if (EARLY_OUT && w_spec) begin
                  r_state  <= DONE;
                  r_valid  <= 1'b1;
                  r_result <= w_spec_val;
               end else r_state <= CALC;
            end
            CALC: begin
               r_acc <= w_acc_nx;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'(XLEN-1)) begin
                  r_state  <= DONE;
                  r_valid  <= 1'b1;
                  r_result <= w_calc_res;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed vector bench for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_flush = 1'b0;
   logic [2:0]  i_func3 = '0;
   logic [31:0] i_op1 = '0, i_op2 = '0;
   logic [4:0]  i_rd = '0;
   logic        o_stall, o_valid;
   logic [31:0] o_result;
   logic [4:0]  o_rd;
   int checks = 0, errors = 0;
   ex_muldiv_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_func3(i_func3), .i_op1(i_op1),
      .i_op2(i_op2), .i_rd(i_rd), .i_flush(i_flush), .o_stall(o_stall), .o_valid(o_valid),
      .o_result(o_result), .o_rd(o_rd)
   );
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;
   vec_t v[24];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask
   // Starts at a point before the rising edge in an IDLE cycle; returns right after
   // the negedge following the DONE cycle.
   task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit hold, output logic [31:0] res,
                      output logic [4:0] rdo, output int lat, output int stl);
      bit got_v = 1'b0;
      i_func3 = f3; i_op1 = a; i_op2 = b; i_rd = rd; i_start = 1'b1;
      #1;
      lat = 0;
      stl = int'(o_stall);
      while (!got_v && lat < 40) begin
         @(negedge clk);
         lat++;
         if (o_valid) got_v = 1'b1;
         else stl += int'(o_stall);
         if (hold) begin
            i_op1 = $urandom; i_op2 = $urandom; i_func3 = 3'($urandom); i_rd = 5'($urandom);
         end else i_start = 1'b0;
      end
      res = o_result;
      rdo = o_rd;
      @(negedge clk);
      i_start = 1'b0;
      #1;
      chk("valid_one_cycle", 32'(o_valid), 32'd0);
      chk("idle_after_done", 32'(o_stall), 32'd0);
   endtask
   logic [31:0] res;
   logic [4:0]  rdo;
   int lat, stl, nv;
   initial begin
      v[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      v[1]  = '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 33};
      v[2]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      v[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      v[4]  = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
      v[5]  = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
      v[6]  = '{3'b101, 32'h12345678,  32'h00000000, 32'hFFFFFFFF, 1};
      v[7]  = '{3'b111, 32'd5,         32'h00000000, 32'd5,        1};
      v[8]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
      v[9]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
      v[10] = '{3'b101, 32'd100,       32'd7,        32'd14,       33};
      v[11] = '{3'b111, 32'd100,       32'd7,        32'd2,        33};
      v[12] = '{3'b000, 32'd0,         32'h1234,     32'd0,        1};
      v[13] = '{3'b001, 32'h1234,      32'd0,        32'd0,        1};
      v[14] = '{3'b000, 32'h00010000,  32'h00010000, 32'd0,        33};
      v[15] = '{3'b011, 32'h00010000,  32'h00010000, 32'd1,        33};
      v[16] = '{3'b010, 32'd2,         32'h80000000, 32'd1,        33};
      v[17] = '{3'b001, 32'd2,         32'h80000000, 32'hFFFFFFFF, 33};
      v[18] = '{3'b100, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 33};
      v[19] = '{3'b110, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 33};
      v[20] = '{3'b100, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 33};
      v[21] = '{3'b110, 32'd100,       32'hFFFFFFF9, 32'd2,        33};
      v[22] = '{3'b100, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 1};
      v[23] = '{3'b110, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 1};
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_rd", 32'(o_rd), 32'd0);
      chk("rst_stall", 32'(o_stall), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      foreach (v[i]) begin
         run(v[i].f3, v[i].a, v[i].b, 5'(i + 1), 1'b0, res, rdo, lat, stl);
         chk($sformatf("vec%0d_result", i), res, v[i].res);
         chk($sformatf("vec%0d_rd", i), 32'(rdo), 32'(i + 1));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("vec%0d_stall_cycles", i), 32'(stl), 32'(v[i].lat));
      end
      // i_start held and operands scrambled during CALC and DONE
      run(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b1, res, rdo, lat, stl);
      chk("hold_result", res, 32'hFFFFFFEB);
      chk("hold_rd", 32'(rdo), 32'd9);
      chk("hold_latency", 32'(lat), 32'd33);
      // flush at counter 10, then a new MUL on the very next cycle
      i_func3 = 3'b000; i_op1 = 32'd9; i_op2 = 32'd9; i_rd = 5'd3; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (10) @(negedge clk);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      #1;
      chk("flush_stall", 32'(o_stall), 32'd0);
      chk("flush_valid", 32'(o_valid), 32'd0);
      run(3'b000, 32'd3, 32'd4, 5'd7, 1'b0, res, rdo, lat, stl);
      chk("post_flush_result", res, 32'd12);
      chk("post_flush_rd", 32'(rdo), 32'd7);
      chk("post_flush_latency", 32'(lat), 32'd33);
      // flush beats start in IDLE (an accepted zero-MUL would be valid next cycle)
      i_func3 = 3'b000; i_op1 = 32'd0; i_op2 = 32'd5; i_rd = 5'd4; i_start = 1'b1; i_flush = 1'b1;
      #1;
      chk("flush_win_stall", 32'(o_stall), 32'd0);
      @(negedge clk);
      i_start = 1'b0; i_flush = 1'b0;
      #1;
      chk("flush_win_valid", 32'(o_valid), 32'd0);
      chk("flush_win_rd", 32'(o_rd), 32'd7);
      // asynchronous reset mid-CALC
      i_func3 = 3'b000; i_op1 = 32'd3; i_op2 = 32'd4; i_rd = 5'd11; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_stall", 32'(o_stall), 32'd0);
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_result", o_result, 32'd0);
      chk("midrst_rd", 32'(o_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         nv += int'(o_valid);
      end
      chk("midrst_no_valid", 32'(nv), 32'd0);
      chk("midrst_idle", 32'(o_stall), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
